img_frame_streamer: RTL and testbench

IMG_FRAME_STREAMER -- requirements
Module: img_frame_streamer

---
 rtl/img_stream_pkg.sv | 28 ++
 rtl/img_skid_buf.sv | 72 +++++++
 rtl/img_frame_streamer.sv | 193 +++++++++++++++++++
 tb/tb_img_frame_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_stream_pkg.sv
//==============================================================================
// Module   : img_stream_pkg
// Purpose  : Shared types and default geometry for the image frame streamer.
//            Holds the streamer FSM state encoding and default parameter values.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

package img_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int c_DEF_PIX_W  = 8;
    localparam int c_DEF_CH     = 1;
    localparam int c_DEF_IMG_W  = 512;
    localparam int c_DEF_IMG_H  = 512;
    localparam int c_DEF_ADDR_W = 18;

    // Side-band flags carried next to each pixel: {eof, eol, sof}
    localparam int c_TAG_W = 3;

endpackage

`default_nettype wire

// File: rtl/img_skid_buf.sv
//==============================================================================
// Module   : img_skid_buf
// Purpose  : Two-entry fall-through skid buffer for the streamer output path.
//            An arriving word goes straight to the output when the buffer is
//            empty and is stored when it cannot be accepted immediately.
// Ports    : clk, rst    - clock, asynchronous active-high reset
//            i_data/i_vld - incoming word (no back-pressure; the producer
//                           guarantees space through o_cnt)
//            o_data/o_vld - head word, held stable while i_rdy is low
//            i_rdy        - downstream accept
//            o_cnt        - number of stored words (0..2)
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module img_skid_buf #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_vld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [1:0]       o_cnt
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_head;
    logic [1:0]       r_cnt;

    logic w_empty;
    logic w_pop;
    logic w_bypass;
    logic w_push;
    logic w_pop_mem;
    logic w_wr_idx;

    assign w_empty   = (r_cnt == 2'd0);
    assign o_vld     = !w_empty || i_vld;
    // Empty output is forced to zero so idle dout/flags read as 0
    assign o_data    = !w_empty ? r_mem[r_head] : (i_vld ? i_data : '0);
    assign w_pop     = o_vld && i_rdy;
    // Word arriving into an empty buffer and accepted the same cycle never stored
    assign w_bypass  = w_empty && i_vld && i_rdy;
    assign w_push    = i_vld && !w_bypass;
    assign w_pop_mem = w_pop && !w_empty;
    // Tail slot is head+cnt modulo 2; a push never happens while full
    assign w_wr_idx  = r_head ^ r_cnt[0];
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[w_wr_idx] <= i_data;
            end
            if (w_pop_mem) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop_mem};
        end
    end

endmodule

`default_nettype wire

// File: rtl/img_frame_streamer.sv
//==============================================================================
// Module   : img_frame_streamer
// Purpose  : Reads one image frame from a pixel memory in raster order and
//            streams it out with valid/ready handshake and sof/eol/eof flags.
//            Build option: define IMG_STREAM_LOOP_EN to repeat frames
//            continuously until the added stop input is raised.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            stop              - (IMG_STREAM_LOOP_EN only) end after this frame
//            start             - single-cycle frame request
//            addr, rd_en, din  - pixel memory read port (1-cycle latency)
//            dout, out_en      - streamed pixel and its valid
//            out_rdy           - downstream accept
//            sof, eol, eof     - frame/line markers qualified by out_en
//            busy, complete    - frame in progress / end-of-frame pulse
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module img_frame_streamer
    import img_stream_pkg::*;
#(
    parameter int PIX_W  = c_DEF_PIX_W,
    parameter int CH     = c_DEF_CH,
    parameter int IMG_W  = c_DEF_IMG_W,
    parameter int IMG_H  = c_DEF_IMG_H,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef IMG_STREAM_LOOP_EN
    input  logic                  stop,
`endif
    input  logic                  start,
    output logic [ADDR_W-1:0]     addr,
    output logic                  rd_en,
    input  logic [PIX_W*CH-1:0]   din,
    output logic [PIX_W*CH-1:0]   dout,
    output logic                  out_en,
    input  logic                  out_rdy,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  complete
);

    localparam int DW    = PIX_W * CH;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0]  c_COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  c_ROW_LAST  = ROW_W'(IMG_H - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic                r_rd_en;
    logic                r_vld;
    logic [c_TAG_W-1:0]  r_tag;
    logic                r_busy;
    logic                r_complete;

    logic [DW+c_TAG_W-1:0] w_skid_out;
    logic                  w_out_vld;
    logic [1:0]            w_cnt;
    logic                  w_pop;
    logic                  w_stop;
    logic                  w_col_last;
    logic                  w_last_rd;
    logic [c_TAG_W-1:0]    w_rd_tag;
    logic [2:0]            w_credit;
    logic                  w_credit_ok;
    logic                  w_eof_pop;

`ifdef IMG_STREAM_LOOP_EN
    assign w_stop = stop;
`else
    // Single-frame build behaves as if stop were permanently requested
    assign w_stop = 1'b1;
`endif

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_last_rd  = r_rd_en && (r_addr == c_LAST_ADDR);
    // Flags of the pixel currently being read: {eof, eol, sof}
    assign w_rd_tag   = {w_col_last && (r_row == c_ROW_LAST), w_col_last, r_addr == '0};

    assign w_pop      = w_out_vld && out_rdy;
    assign w_eof_pop  = w_pop && w_skid_out[DW+2];

    // Occupancy seen after this edge: stored words after this cycle's push/pop
    // plus the read completing now (lands next cycle). A new read is allowed
    // only while that total is below the buffer depth.
    assign w_credit    = {1'b0, w_cnt} + {2'b0, r_vld} + {2'b0, r_rd_en} - {2'b0, w_pop};
    assign w_credit_ok = (w_credit < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_rd_en    <= 1'b0;
            r_vld      <= 1'b0;
            r_tag      <= '0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            r_vld      <= r_rd_en;

            // Address and raster counters step once per issued read
            if (r_rd_en) begin
                r_tag <= w_rd_tag;
                if (r_addr == c_LAST_ADDR) begin
                    r_addr <= '0;
                    r_col  <= '0;
                    r_row  <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Only reachable in looping builds: a frame ends while reads
                    // for the next frame are already flowing
                    if (w_eof_pop) begin
                        r_complete <= 1'b1;
                    end
                    if (w_last_rd && w_stop) begin
                        r_state <= ST_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_en <= w_credit_ok;
                    end
                end
                ST_DRAIN: begin
                    r_rd_en <= 1'b0;
                    if (w_eof_pop) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_complete <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    img_skid_buf #(
        .WIDTH (DW + c_TAG_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_data ({r_tag, din}),
        .i_vld  (r_vld),
        .o_data (w_skid_out),
        .o_vld  (w_out_vld),
        .i_rdy  (out_rdy),
        .o_cnt  (w_cnt)
    );

    assign addr     = r_addr;
    assign rd_en    = r_rd_en;
    assign dout     = w_skid_out[DW-1:0];
    assign sof      = w_skid_out[DW];
    assign eol      = w_skid_out[DW+1];
    assign eof      = w_skid_out[DW+2];
    assign out_en   = w_out_vld;
    assign busy     = r_busy;
    assign complete = r_complete;

endmodule

`default_nettype wire

// File: tb/tb_img_frame_streamer.sv
//==============================================================================
// Module   : tb_img_frame_streamer
// Purpose  : Directed self-checking bench for img_frame_streamer on a 4x3
//            frame of 3x8-bit pixels, memory word k = {k+2, k+1, k}.
//            Looping scenario is compiled when IMG_STREAM_LOOP_EN is defined.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_img_frame_streamer;

    localparam int PIX_W  = 8;
    localparam int CH     = 3;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int ADDR_W = 4;
    localparam int NPIX   = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  addr;
    logic        rd_en;
    logic [23:0] din = '0;
    logic [23:0] dout;
    logic        out_en;
    logic        out_rdy;
    logic        sof, eol, eof;
    logic        busy;
    logic        complete;
`ifdef IMG_STREAM_LOOP_EN
    logic        stop;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Monitor-owned event counters
    int n_beats = 0;
    int n_sof   = 0;
    int n_cmpl  = 0;
    int exp_idx = 0;
    int exp_rd  = 0;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_word  = '0;

    int b0, s0, c0;

    always #5 clk = ~clk;

    img_frame_streamer #(
        .PIX_W  (PIX_W),
        .CH     (CH),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef IMG_STREAM_LOOP_EN
        .stop     (stop),
`endif
        .start    (start),
        .addr     (addr),
        .rd_en    (rd_en),
        .din      (din),
        .dout     (dout),
        .out_en   (out_en),
        .out_rdy  (out_rdy),
        .sof      (sof),
        .eol      (eol),
        .eof      (eof),
        .busy     (busy),
        .complete (complete)
    );

    function automatic logic [23:0] word(input int k);
        logic [7:0] a, b, c;
        a = 8'(k);
        b = 8'(k + 1);
        c = 8'(k + 2);
        return {c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pixel memory with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) din <= word({28'd0, addr});
    end

    // Stream monitor: read address order, beat content/flags, stall stability
    always @(negedge clk) begin
        if (rst) begin
            exp_idx    = 0;
            exp_rd     = 0;
            prev_stall = 1'b0;
        end else begin
            if (rd_en) begin
                chk("rd_addr", {28'd0, addr}, exp_rd);
                exp_rd = (exp_rd == NPIX - 1) ? 0 : exp_rd + 1;
            end
            if (prev_stall) begin
                chk("stall_en", 32'(out_en), 32'd1);
                chk("stall_hold", {5'd0, eof, eol, sof, dout}, {5'd0, prev_word});
            end
            if (complete) n_cmpl++;
            if (out_en && out_rdy) begin
                chk("dout", {8'd0, dout}, {8'd0, word(exp_idx)});
                chk("sof", 32'(sof), (exp_idx == 0) ? 32'd1 : 32'd0);
                chk("eol", 32'(eol), (exp_idx % IMG_W == IMG_W - 1) ? 32'd1 : 32'd0);
                chk("eof", 32'(eof), (exp_idx == NPIX - 1) ? 32'd1 : 32'd0);
                if (sof) n_sof++;
                n_beats++;
                exp_idx = (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
            end
            prev_stall = out_en && !out_rdy;
            prev_word  = {eof, eol, sof, dout};
        end
    end

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 300 && busy; i++) @(posedge clk) #1;
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        out_rdy = 1'b1;
`ifdef IMG_STREAM_LOOP_EN
        stop    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", {28'd0, addr}, 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_dout", {8'd0, dout}, 32'd0);
        chk("rst_out_en", 32'(out_en), 32'd0);
        chk("rst_flags", {29'd0, eof, eol, sof}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);
        @(posedge clk) #1 rst = 1'b0;

        // Full-rate frame: latency, gap-free beats, complete timing
        b0 = n_beats; c0 = n_cmpl;
        pulse_start();
        @(negedge clk);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        chk("t1_first_rd", 32'(rd_en), 32'd1);
        chk("t1_no_early_out", 32'(out_en), 32'd0);
        @(negedge clk);
        chk("t1_latency", 32'(out_en), 32'd1);
        for (int i = 1; i < NPIX; i++) begin
            @(negedge clk);
            chk("t1_gapfree", 32'(out_en), 32'd1);
        end
        @(negedge clk);
        chk("t1_complete", 32'(complete), 32'd1);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_out_idle", 32'(out_en), 32'd0);
        @(negedge clk);
        chk("t1_complete_pulse", 32'(complete), 32'd0);
        @(posedge clk) #1;
        chk("t1_beats", n_beats - b0, NPIX);
        chk("t1_ncmpl", n_cmpl - c0, 32'd1);

        // Back-pressure pattern 1,0,0 repeating
        b0 = n_beats; c0 = n_cmpl;
        pulse_start();
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_rdy = (cyc % 3 == 0);
            @(posedge clk) #1;
            if (!busy) break;
        end
        out_rdy = 1'b1;
        chk("t2_idle", 32'(busy), 32'd0);
        @(posedge clk) #1;
        chk("t2_beats", n_beats - b0, NPIX);
        chk("t2_ncmpl", n_cmpl - c0, 32'd1);

        // Repeated start mid-frame is ignored
        b0 = n_beats; c0 = n_cmpl;
        pulse_start();
        for (int i = 0; i < 50 && (n_beats - b0) < 5; i++) @(posedge clk) #1;
        chk("t3_reach5", n_beats - b0, 32'd5);
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        wait_idle("t3_idle");
        repeat (5) @(posedge clk) #1;
        chk("t3_beats", n_beats - b0, NPIX);
        chk("t3_ncmpl", n_cmpl - c0, 32'd1);
        chk("t3_no_restart", 32'(busy), 32'd0);

        // Reset mid-frame, then a clean frame
        b0 = n_beats;
        pulse_start();
        for (int i = 0; i < 50 && (n_beats - b0) < 6; i++) @(posedge clk) #1;
        chk("t4_reach6", n_beats - b0, 32'd6);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_addr", {28'd0, addr}, 32'd0);
        chk("t4_rd_en", 32'(rd_en), 32'd0);
        chk("t4_out", {7'd0, out_en, dout}, 32'd0);
        chk("t4_flags", {29'd0, eof, eol, sof}, 32'd0);
        chk("t4_busy_cmpl", {30'd0, busy, complete}, 32'd0);
        @(posedge clk) #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_wait_start", {30'd0, busy, out_en}, 32'd0);
        b0 = n_beats; s0 = n_sof; c0 = n_cmpl;
        pulse_start();
        wait_idle("t4_idle");
        @(posedge clk) #1;
        chk("t4_beats", n_beats - b0, NPIX);
        chk("t4_sof", n_sof - s0, 32'd1);
        chk("t4_ncmpl", n_cmpl - c0, 32'd1);

`ifdef IMG_STREAM_LOOP_EN
        // Looping: stop raised during the second frame
        b0 = n_beats; s0 = n_sof; c0 = n_cmpl;
        pulse_start();
        for (int i = 0; i < 100 && (n_cmpl - c0) < 1; i++) @(posedge clk) #1;
        chk("t5_frame1", n_cmpl - c0, 32'd1);
        chk("t5_busy_held", 32'(busy), 32'd1);
        stop = 1'b1;
        wait_idle("t5_idle");
        repeat (5) @(posedge clk) #1;
        stop = 1'b0;
        chk("t5_beats", n_beats - b0, 2 * NPIX);
        chk("t5_sof", n_sof - s0, 32'd2);
        chk("t5_ncmpl", n_cmpl - c0, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
